// File: rtl/sr_cmd_debounce.sv
// sr_cmd_debounce: synchronizes and debounces set/clear buttons into exclusive one-cycle S/R command pulses.
module sr_cmd_debounce #(
   parameter int DB_CYCLES    = 4,
   parameter int GAP_CYCLES   = 2,
   parameter int CLR_PRIORITY = 1
)(
   input  logic clk,
   input  logic rst,
   input  logic set_btn,
   input  logic clr_btn,
   output logic S,
   output logic R,
   output logic set_db,
   output logic clr_db,
   output logic busy,
   output logic conflict
);
   localparam int CW = $clog2(DB_CYCLES + 1);
   localparam int GW = $clog2(GAP_CYCLES + 2);
   typedef enum logic [1:0] {IDLE, ISSUE, HOLDOFF} state_t;
   logic [1:0] w_btn, w_db, w_rise, w_clr;
   logic       w_win;
   state_t     r_state;
   logic       r_cmd, r_s, r_r, r_conflict;
   logic [1:0] r_pend;
   logic [GW-1:0] r_gap;
   assign w_btn = {clr_btn, set_btn};
   genvar c;
   for (c = 0; c < 2; c++) begin : g_ch
      logic [2:0]    r_sync;
      logic [CW-1:0] r_cnt;
      logic          r_db, r_db_d;
      // r_sync[2] is the synchronized level the debouncer watches
      always_ff @(posedge clk) begin
         if (rst) begin
            r_sync <= '0;
            r_cnt  <= '0;
            r_db   <= 1'b0;
            r_db_d <= 1'b0;
         end else begin
            r_sync <= {r_sync[1:0], w_btn[c]};
            r_db_d <= r_db;
            if (r_sync[2] == r_db) r_cnt <= '0;
            else if (r_cnt == CW'(DB_CYCLES - 1)) begin
               r_cnt <= '0;
               r_db  <= ~r_db;
            end else r_cnt <= r_cnt + 1'b1;
         end
      end
      assign w_db[c]   = r_db;
      assign w_rise[c] = r_db & ~r_db_d;
   end
   // bit 1 = clear channel; a fresh rising edge survives a same-cycle clear
   assign w_win = (&r_pend) ? (CLR_PRIORITY != 0) : r_pend[1];
   assign w_clr = (r_state == ISSUE) ? (r_cmd ? 2'b10 : 2'b01) :
                  (r_state == IDLE && &r_pend) ? (w_win ? 2'b01 : 2'b10) : 2'b00;
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= IDLE;
         r_cmd      <= 1'b0;
         r_s        <= 1'b0;
         r_r        <= 1'b0;
         r_conflict <= 1'b0;
         r_pend     <= 2'b00;
         r_gap      <= '0;
      end else begin
         r_s        <= 1'b0;
         r_r        <= 1'b0;
         r_conflict <= 1'b0;
         r_pend     <= (r_pend & ~w_clr) | w_rise;
         case (r_state)
            IDLE: if (|r_pend) begin
               r_state    <= ISSUE;
               r_cmd      <= w_win;
               r_s        <= ~w_win;
               r_r        <= w_win;
               r_conflict <= &r_pend;
            end
            ISSUE: begin
               r_state <= (GAP_CYCLES > 0) ? HOLDOFF : IDLE;
               r_gap   <= GW'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);
            end
            HOLDOFF: if (r_gap == '0) r_state <= IDLE;
                     else r_gap <= r_gap - 1'b1;
            default: r_state <= IDLE;
         endcase
      end
   end
   assign S        = r_s;
   assign R        = r_r;
   assign set_db   = w_db[0];
   assign clr_db   = w_db[1];
   assign busy     = r_state != IDLE;
   assign conflict = r_conflict;
endmodule

// File: tb/tb_sr_cmd_debounce.sv
// tb_sr_cmd_debounce: directed plus random stimulus on two configurations, checked against a history-based reference model.
module tb_sr_cmd_debounce;
   localparam int N = 4096;
   logic clk = 1'b0, rst = 1'b1, set_btn = 1'b0, clr_btn = 1'b0;
   logic S0, R0, sd0, cd0, b0, cf0, S1, R1, sd1, cd1, b1, cf1;
   always #5 clk = ~clk;
   sr_cmd_debounce u0 (.clk(clk), .rst(rst), .set_btn(set_btn), .clr_btn(clr_btn),
      .S(S0), .R(R0), .set_db(sd0), .clr_db(cd0), .busy(b0), .conflict(cf0));
   sr_cmd_debounce #(.DB_CYCLES(3), .GAP_CYCLES(0), .CLR_PRIORITY(0)) u1 (.clk(clk), .rst(rst),
      .set_btn(set_btn), .clr_btn(clr_btn), .S(S1), .R(R1), .set_db(sd1), .clr_db(cd1), .busy(b1), .conflict(cf1));
   int checks = 0, failures = 0, n = 0, last_rst = 0;
   int dbp[2] = '{4, 3};
   int gapp[2] = '{2, 0};
   bit prip[2] = '{1'b1, 1'b0};
   bit raw[2][N];
   bit sy[2][2][N];
   bit db[2][2][N];
   bit pend[2][2];
   bit cmd[2];
   bit conf[2];
   int last_iss[2] = '{-100, -100};
   int s0_cnt, r0_cnt, c0_cnt, s0_at, r0_at, t0;
   task automatic clr_counts();
      s0_cnt = 0; r0_cnt = 0; c0_cnt = 0; s0_at = -1; r0_at = -1;
   endtask
   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask
   // One clock: drive inputs, advance the model for that edge, compare all outputs of both instances
   task automatic tick(input bit s, input bit c, input bit rs);
      bit [5:0] e[2];
      bit [5:0] o[2];
      bit rise[2];
      bit both, idle, win, ok;
      set_btn = s; clr_btn = c; rst = rs;
      @(posedge clk);
      n++;
      raw[0][n] = s; raw[1][n] = c;
      if (rs) last_rst = n;
      for (int i = 0; i < 2; i++) begin
         if (rs) begin
            for (int ch = 0; ch < 2; ch++) begin
               sy[i][ch][n] = 0; db[i][ch][n] = 0; pend[i][ch] = 0;
            end
            last_iss[i] = -100; conf[i] = 0; cmd[i] = 0;
         end else begin
            for (int ch = 0; ch < 2; ch++) begin
               sy[i][ch][n] = (n - 2 > last_rst) ? raw[ch][n-2] : 1'b0;
               ok = (n - dbp[i] >= last_rst);
               if (ok) for (int k = 1; k <= dbp[i]; k++) if (sy[i][ch][n-k] == db[i][ch][n-1]) ok = 0;
               db[i][ch][n] = ok ? ~db[i][ch][n-1] : db[i][ch][n-1];
               rise[ch] = (n - 2 >= last_rst) && db[i][ch][n-1] && !db[i][ch][n-2];
            end
            idle = n >= last_iss[i] + gapp[i] + 2;
            conf[i] = 0;
            if (last_iss[i] == n - 1) pend[i][cmd[i]] = 0;
            if (idle && (pend[i][0] || pend[i][1])) begin
               both = pend[i][0] && pend[i][1];
               win = both ? prip[i] : pend[i][1];
               cmd[i] = win; last_iss[i] = n; conf[i] = both;
               if (both) pend[i][!win] = 0;
            end
            for (int ch = 0; ch < 2; ch++) pend[i][ch] = pend[i][ch] | rise[ch];
         end
         e[i] = {last_iss[i] == n && !cmd[i], last_iss[i] == n && cmd[i], db[i][0][n], db[i][1][n],
                 n >= last_iss[i] && n <= last_iss[i] + gapp[i], conf[i]};
      end
      #1;
      o[0] = {S0, R0, sd0, cd0, b0, cf0};
      o[1] = {S1, R1, sd1, cd1, b1, cf1};
      for (int i = 0; i < 2; i++) begin
         checks++;
         assert (o[i] === e[i]) else begin
            failures++;
            $error("FAIL u%0d_outs cyc=%0d got={S,R,sdb,cdb,busy,conf}=%b exp=%b", i, n, o[i], e[i]);
         end
      end
      if (S0) begin s0_cnt++; s0_at = n; end
      if (R0) begin r0_cnt++; r0_at = n; end
      if (cf0) c0_cnt++;
   endtask
   initial begin
      int rs_left, rc_left;
      bit ls, lc;
      repeat (3) tick(0, 0, 1);
      chk("reset_outs", {S0, R0, sd0, cd0, b0, cf0, S1, R1, sd1, cd1, b1, cf1}, 0);
      repeat (5) tick(0, 0, 0);
      clr_counts(); t0 = n + 1;
      repeat (20) tick(1, 0, 0);
      repeat (20) tick(0, 0, 0);
      chk("press_s_cnt", s0_cnt, 1);
      chk("press_latency", s0_at, t0 + 8);
      chk("press_r_cnt", r0_cnt, 0);
      clr_counts();
      repeat (3) tick(0, 1, 0);
      repeat (2) tick(0, 0, 0);
      repeat (3) tick(0, 1, 0);
      repeat (20) tick(0, 0, 0);
      chk("bounce_r_cnt", r0_cnt, 0);
      clr_counts();
      repeat (20) tick(1, 1, 0);
      repeat (20) tick(0, 0, 0);
      chk("simul_r_cnt", r0_cnt, 1);
      chk("simul_s_cnt", s0_cnt, 0);
      chk("simul_conflict", c0_cnt, 1);
      clr_counts();
      repeat (2) tick(1, 0, 0);
      repeat (18) tick(1, 1, 0);
      repeat (20) tick(0, 0, 0);
      chk("holdoff_s_cnt", s0_cnt, 1);
      chk("holdoff_r_cnt", r0_cnt, 1);
      chk("holdoff_spacing", r0_at - s0_at, 4);
      chk("holdoff_conflict", c0_cnt, 0);
      clr_counts();
      repeat (6) tick(1, 0, 0);
      tick(1, 0, 1);
      chk("rst_set_db", sd0, 0);
      t0 = n + 1;
      repeat (20) tick(1, 0, 0);
      chk("rst_s_cnt", s0_cnt, 1);
      chk("rst_latency", s0_at, t0 + 8);
      repeat (20) tick(0, 0, 0);
      clr_counts();
      repeat (20) tick(1, 0, 0);
      repeat (20) tick(0, 0, 0);
      repeat (20) tick(1, 0, 0);
      repeat (20) tick(0, 0, 0);
      chk("repeat_s_cnt", s0_cnt, 2);
      ls = 0; lc = 0; rs_left = 0; rc_left = 0;
      for (int j = 0; j < 800; j++) begin
         if (rs_left == 0) begin ls = $urandom_range(0, 1); rs_left = $urandom_range(1, 12); end
         if (rc_left == 0) begin lc = $urandom_range(0, 1); rc_left = $urandom_range(1, 12); end
         rs_left--; rc_left--;
         tick(ls, lc, $urandom_range(0, 199) == 0);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
